// File: rtl/scaling_cfg_sequencer.sv
// scaling_cfg_sequencer
// AXI4-Lite master that writes NUM_REGS configuration words to consecutive
// registers of the scaling interface after a single start pulse. It can then
// read each word back and compare it. It reports completion and the first
// failure seen.
//
// Ports:
//   ACLK, ARESET      clock, synchronous active-high reset
//   start             begin a sequence (sampled only while idle)
//   cfg_data          NUM_REGS packed 32-bit words, word i at [32i+31:32i]
//   busy, done        sequence in progress / one-cycle completion pulse
//   error, err_code   first failure: 1 = bad response, 2 = mismatch, 3 = timeout
//   err_index         register index of the first failure
//   M_AXI_*           AXI4-Lite master channels (AW, W, B, AR, R)
module scaling_cfg_sequencer #(
   parameter int unsigned                   C_M_AXI_ADDR_WIDTH = 32,
   parameter int unsigned                   C_M_AXI_DATA_WIDTH = 32,
   parameter int unsigned                   NUM_REGS           = 4,
   parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR          = '0,
   parameter int unsigned                   VERIFY             = 1,
   parameter int unsigned                   TIMEOUT_CYCLES     = 255
) (
   input  logic                            ACLK,
   input  logic                            ARESET,
   input  logic                            start,
   input  logic [32*NUM_REGS-1:0]          cfg_data,
   output logic                            busy,
   output logic                            done,
   output logic                            error,
   output logic [1:0]                      err_code,
   output logic [3:0]                      err_index,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
   output logic [2:0]                      M_AXI_AWPROT,
   output logic                            M_AXI_AWVALID,
   input  logic                            M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
   output logic                            M_AXI_WVALID,
   input  logic                            M_AXI_WREADY,
   input  logic [1:0]                      M_AXI_BRESP,
   input  logic                            M_AXI_BVALID,
   output logic                            M_AXI_BREADY,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
   output logic [2:0]                      M_AXI_ARPROT,
   output logic                            M_AXI_ARVALID,
   input  logic                            M_AXI_ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
   input  logic [1:0]                      M_AXI_RRESP,
   input  logic                            M_AXI_RVALID,
   output logic                            M_AXI_RREADY
);

   localparam int unsigned TW      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [3:0]  LastIdx = 4'(NUM_REGS - 1);

   typedef enum logic [2:0] {
      StIdle,
      StWrReq,
      StWrResp,
      StRdReq,
      StRdResp,
      StDone
   } state_e;

   state_e                        state_q, state_d;
   logic [3:0]                    idx_q, idx_d;
   logic [TW-1:0]                 cnt_q, cnt_d;
   logic                          aw_done_q, aw_done_d;
   logic                          w_done_q, w_done_d;
   logic [32*NUM_REGS-1:0]        cfg_q;
   logic                          error_q;
   logic [1:0]                    err_code_q;
   logic [3:0]                    err_index_q;

   logic                          err_set;
   logic [1:0]                    err_code_d;
   logic [C_M_AXI_DATA_WIDTH-1:0] cur_word;
   logic [C_M_AXI_ADDR_WIDTH-1:0] cur_addr;
   logic                          aw_hs, w_hs, aw_ok, w_ok, timeout;

   // Word for the current index, selected with constant slices only.
   always_comb begin
      cur_word = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (idx_q == 4'(i)) cur_word = cfg_q[32*i +: 32];
      end
   end

   assign cur_addr = BASE_ADDR + C_M_AXI_ADDR_WIDTH'({idx_q, 2'b00});

   assign aw_hs   = M_AXI_AWVALID && M_AXI_AWREADY;
   assign w_hs    = M_AXI_WVALID && M_AXI_WREADY;
   // Each write channel completes independently; both must be done to leave.
   assign aw_ok   = aw_done_q || aw_hs;
   assign w_ok    = w_done_q || w_hs;
   // Counter starts at 0 on state entry, so this fires TIMEOUT_CYCLES cycles in.
   assign timeout = (cnt_q == TW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      err_set    = 1'b0;
      err_code_d = 2'd0;

      case (state_q)
         StIdle: begin
            if (start) begin
               idx_d   = '0;
               state_d = StWrReq;
            end
         end
         StWrReq: begin
            if (aw_ok && w_ok) begin
               state_d = StWrResp;
            end else if (timeout) begin
               err_set    = 1'b1;
               err_code_d = 2'd3;
               state_d    = StDone;
            end
         end
         StWrResp: begin
            if (M_AXI_BVALID) begin
               if (M_AXI_BRESP != 2'b00) begin
                  err_set    = 1'b1;
                  err_code_d = 2'd1;
                  state_d    = StDone;
               end else if (idx_q == LastIdx) begin
                  idx_d = '0;
                  if (VERIFY != 0) state_d = StRdReq;
                  else             state_d = StDone;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  state_d = StWrReq;
               end
            end else if (timeout) begin
               err_set    = 1'b1;
               err_code_d = 2'd3;
               state_d    = StDone;
            end
         end
         StRdReq: begin
            if (M_AXI_ARREADY) begin
               state_d = StRdResp;
            end else if (timeout) begin
               err_set    = 1'b1;
               err_code_d = 2'd3;
               state_d    = StDone;
            end
         end
         StRdResp: begin
            if (M_AXI_RVALID) begin
               if (M_AXI_RRESP != 2'b00) begin
                  err_set    = 1'b1;
                  err_code_d = 2'd1;
                  state_d    = StDone;
               end else if (M_AXI_RDATA != cur_word) begin
                  err_set    = 1'b1;
                  err_code_d = 2'd2;
                  state_d    = StDone;
               end else if (idx_q == LastIdx) begin
                  state_d = StDone;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  state_d = StRdReq;
               end
            end else if (timeout) begin
               err_set    = 1'b1;
               err_code_d = 2'd3;
               state_d    = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Per-state counter: restarts on every state change, including a hop back
   // into WR_REQ/RD_REQ for the next index.
   always_comb begin
      cnt_d = '0;
      if (busy && (state_d == state_q)) cnt_d = cnt_q + TW'(1);
   end

   always_comb begin
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
      if ((state_q == StWrReq) && (state_d == StWrReq)) begin
         aw_done_d = aw_done_q || aw_hs;
         w_done_d  = w_done_q || w_hs;
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q     <= StIdle;
         idx_q       <= '0;
         cnt_q       <= '0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         cfg_q       <= '0;
         error_q     <= 1'b0;
         err_code_q  <= 2'd0;
         err_index_q <= 4'd0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         if ((state_q == StIdle) && start) begin
            cfg_q       <= cfg_data;
            error_q     <= 1'b0;
            err_code_q  <= 2'd0;
            err_index_q <= 4'd0;
         end else if (err_set) begin
            error_q     <= 1'b1;
            err_code_q  <= err_code_d;
            err_index_q <= idx_q;
         end
      end
   end

   // Outputs decode registered state only; address/data are zero when not
   // presented so that every output is zero while idle.
   assign busy          = (state_q != StIdle) && (state_q != StDone);
   assign done          = (state_q == StDone);
   assign error         = error_q;
   assign err_code      = err_code_q;
   assign err_index     = err_index_q;

   assign M_AXI_AWVALID = (state_q == StWrReq) && !aw_done_q;
   assign M_AXI_AWADDR  = (state_q == StWrReq) ? cur_addr : '0;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_WVALID  = (state_q == StWrReq) && !w_done_q;
   assign M_AXI_WDATA   = (state_q == StWrReq) ? cur_word : '0;
   assign M_AXI_WSTRB   = M_AXI_WVALID ? '1 : '0;
   assign M_AXI_BREADY  = (state_q == StWrResp);
   assign M_AXI_ARVALID = (state_q == StRdReq);
   assign M_AXI_ARADDR  = (state_q == StRdReq) ? cur_addr : '0;
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_RREADY  = (state_q == StRdResp);

endmodule

// File: tb/tb_scaling_cfg_sequencer.sv
module tb_scaling_cfg_sequencer;

   localparam int NR       = 4;
   localparam int TO       = 255;
   localparam int EXP_DONE = 1 + 4 * NR;
   localparam int EXP_AR   = 1 + 2 * NR;

   logic              ACLK = 1'b0;
   logic              ARESET = 1'b1;
   logic              start = 1'b0;
   logic [32*NR-1:0]  cfg_data = '0;
   logic              busy, done, error;
   logic [1:0]        err_code;
   logic [3:0]        err_index;
   logic [31:0]       M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR;
   logic [31:0]       M_AXI_RDATA = '0;
   logic [2:0]        M_AXI_AWPROT, M_AXI_ARPROT;
   logic [3:0]        M_AXI_WSTRB;
   logic              M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
   logic              M_AXI_AWREADY = 1'b0, M_AXI_WREADY = 1'b0, M_AXI_ARREADY = 1'b0;
   logic              M_AXI_BVALID = 1'b0, M_AXI_RVALID = 1'b0;
   logic [1:0]        M_AXI_BRESP = 2'b00, M_AXI_RRESP = 2'b00;

   scaling_cfg_sequencer #(
      .NUM_REGS       (NR),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .ACLK          (ACLK),
      .ARESET        (ARESET),
      .start         (start),
      .cfg_data      (cfg_data),
      .busy          (busy),
      .done          (done),
      .error         (error),
      .err_code      (err_code),
      .err_index     (err_index),
      .M_AXI_AWADDR  (M_AXI_AWADDR),
      .M_AXI_AWPROT  (M_AXI_AWPROT),
      .M_AXI_AWVALID (M_AXI_AWVALID),
      .M_AXI_AWREADY (M_AXI_AWREADY),
      .M_AXI_WDATA   (M_AXI_WDATA),
      .M_AXI_WSTRB   (M_AXI_WSTRB),
      .M_AXI_WVALID  (M_AXI_WVALID),
      .M_AXI_WREADY  (M_AXI_WREADY),
      .M_AXI_BRESP   (M_AXI_BRESP),
      .M_AXI_BVALID  (M_AXI_BVALID),
      .M_AXI_BREADY  (M_AXI_BREADY),
      .M_AXI_ARADDR  (M_AXI_ARADDR),
      .M_AXI_ARPROT  (M_AXI_ARPROT),
      .M_AXI_ARVALID (M_AXI_ARVALID),
      .M_AXI_ARREADY (M_AXI_ARREADY),
      .M_AXI_RDATA   (M_AXI_RDATA),
      .M_AXI_RRESP   (M_AXI_RRESP),
      .M_AXI_RVALID  (M_AXI_RVALID),
      .M_AXI_RREADY  (M_AXI_RREADY)
   );

   always #5 ACLK = ~ACLK;

   int checks = 0;
   int failures = 0;

   // Slave behaviour knobs (written only by the test tasks).
   int aw_lat = 0, w_lat = 0, ar_lat = 0;
   bit ar_never = 1'b0;
   int bresp_err_idx = -1, corrupt_idx = -1;

   // Slave model state.
   logic [31:0] mem [16];
   int          aw_wait = 0, w_wait = 0, ar_wait = 0;
   logic        have_aw = 1'b0, have_w = 1'b0;
   logic [31:0] aw_addr_l = '0, w_data_l = '0;
   logic [31:0] wr_log [$];
   logic [31:0] rd_log [$];

   logic        aw_hs, w_hs, ar_hs, got_aw, got_w;
   logic [31:0] wr_addr, wr_data;
   assign aw_hs   = M_AXI_AWVALID && M_AXI_AWREADY;
   assign w_hs    = M_AXI_WVALID && M_AXI_WREADY;
   assign ar_hs   = M_AXI_ARVALID && M_AXI_ARREADY;
   assign got_aw  = have_aw || aw_hs;
   assign got_w   = have_w || w_hs;
   assign wr_addr = have_aw ? aw_addr_l : M_AXI_AWADDR;
   assign wr_data = have_w ? w_data_l : M_AXI_WDATA;

   // Readies change on the falling edge, away from the DUT's sampling edge.
   always @(negedge ACLK) begin
      M_AXI_AWREADY <= M_AXI_AWVALID && (aw_wait >= aw_lat);
      M_AXI_WREADY  <= M_AXI_WVALID && (w_wait >= w_lat);
      M_AXI_ARREADY <= M_AXI_ARVALID && !ar_never && (ar_wait >= ar_lat);
   end

   always @(posedge ACLK) begin
      if (ARESET) begin
         M_AXI_BVALID <= 1'b0;
         M_AXI_RVALID <= 1'b0;
         have_aw      <= 1'b0;
         have_w       <= 1'b0;
         aw_wait      <= 0;
         w_wait       <= 0;
         ar_wait      <= 0;
      end else begin
         aw_wait <= (M_AXI_AWVALID && !aw_hs) ? aw_wait + 1 : 0;
         w_wait  <= (M_AXI_WVALID && !w_hs) ? w_wait + 1 : 0;
         ar_wait <= (M_AXI_ARVALID && !ar_hs) ? ar_wait + 1 : 0;
         if (aw_hs) begin
            have_aw   <= 1'b1;
            aw_addr_l <= M_AXI_AWADDR;
         end
         if (w_hs) begin
            have_w   <= 1'b1;
            w_data_l <= M_AXI_WDATA;
         end
         if (M_AXI_BVALID && M_AXI_BREADY) M_AXI_BVALID <= 1'b0;
         if (got_aw && got_w && (aw_hs || w_hs)) begin
            mem[wr_addr[5:2]] <= wr_data;
            wr_log.push_back(wr_addr);
            M_AXI_BVALID <= 1'b1;
            M_AXI_BRESP  <= (int'(wr_addr[5:2]) == bresp_err_idx) ? 2'b10 : 2'b00;
            have_aw      <= 1'b0;
            have_w       <= 1'b0;
         end
         if (M_AXI_RVALID && M_AXI_RREADY) M_AXI_RVALID <= 1'b0;
         if (ar_hs) begin
            rd_log.push_back(M_AXI_ARADDR);
            M_AXI_RVALID <= 1'b1;
            M_AXI_RRESP  <= 2'b00;
            M_AXI_RDATA  <= (int'(M_AXI_ARADDR[5:2]) == corrupt_idx) ? 32'd0
                                                                     : mem[M_AXI_ARADDR[5:2]];
         end
      end
   end

   // Run one sequence; cycle k is the k-th falling edge after the start edge.
   int  r_done_cyc, r_first_ar, r_n_done, r_aw_hi, r_w_hi, r_strb_bad;
   bit  r_ar_late;

   task automatic run_seq(input int restart_at, input int reset_at);
      int k;
      r_done_cyc = -1; r_first_ar = -1; r_n_done = 0;
      r_aw_hi = 0; r_w_hi = 0; r_strb_bad = 0; r_ar_late = 1'b0;
      @(negedge ACLK);
      start = 1'b1;
      k = 0;
      while (k < 700) begin
         @(negedge ACLK);
         k++;
         start = (k == restart_at);
         if (k == reset_at) ARESET = 1'b1;
         if (reset_at >= 0 && k == reset_at + 1) begin
            ARESET = 1'b0;
            checks++;
            if ({busy, done, error, err_code, err_index, M_AXI_AWADDR, M_AXI_AWPROT,
                 M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, M_AXI_BREADY,
                 M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID, M_AXI_RREADY} !== '0) begin
               failures++;
               $display("FAIL midrun_reset_zero: outputs not all zero (busy=%0b awvalid=%0b wvalid=%0b awaddr=%h) required 0",
                        busy, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_AWADDR);
            end
         end
         if (M_AXI_ARVALID && r_first_ar < 0) r_first_ar = k;
         if (M_AXI_ARVALID && r_done_cyc >= 0) r_ar_late = 1'b1;
         if (M_AXI_AWVALID) r_aw_hi++;
         if (M_AXI_WVALID) r_w_hi++;
         if (M_AXI_WVALID && M_AXI_WSTRB != 4'hF) r_strb_bad++;
         if (done) begin
            r_n_done++;
            if (r_done_cyc < 0) r_done_cyc = k;
         end
         if (r_done_cyc >= 0 && k >= r_done_cyc + 20) break;
         if (reset_at >= 0 && k >= reset_at + 30) break;
      end
      start = 1'b0;
   endtask

   task automatic load_words(input logic [31:0] w [NR]);
      for (int i = 0; i < NR; i++) cfg_data[32*i +: 32] = w[i];
   endtask

   task automatic pulse_reset();
      @(negedge ACLK);
      ARESET = 1'b1;
      repeat (2) @(negedge ACLK);
      ARESET = 1'b0;
   endtask

   task automatic test_reset();
      ARESET = 1'b1;
      repeat (3) @(negedge ACLK);
      checks++;
      if ({busy, done, error, err_code, err_index, M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
           M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARPROT,
           M_AXI_ARVALID, M_AXI_RREADY} !== '0) begin
         failures++;
         $display("FAIL reset_zero: outputs not all zero (busy=%0b awvalid=%0b) required 0",
                  busy, M_AXI_AWVALID);
      end
      ARESET = 1'b0;
   endtask

   task automatic test_default();
      logic [31:0] w [NR];
      int wb, rb;
      for (int i = 0; i < NR; i++) w[i] = 32'(i + 1);
      load_words(w);
      wb = wr_log.size(); rb = rd_log.size();
      run_seq(-1, -1);
      checks++;
      if (r_done_cyc != EXP_DONE) begin
         failures++; $display("FAIL default_done_cycle: got %0d required %0d", r_done_cyc, EXP_DONE);
      end
      checks++;
      if (error !== 1'b0 || err_code !== 2'd0) begin
         failures++; $display("FAIL default_error: got %0b/%0d required 0/0", error, err_code);
      end
      checks++;
      if (r_first_ar != EXP_AR) begin
         failures++; $display("FAIL default_first_ar: got %0d required %0d", r_first_ar, EXP_AR);
      end
      checks++;
      if (wr_log.size() - wb != NR || rd_log.size() - rb != NR) begin
         failures++;
         $display("FAIL default_counts: got wr=%0d rd=%0d required %0d", wr_log.size() - wb,
                  rd_log.size() - rb, NR);
      end else begin
         for (int i = 0; i < NR; i++) begin
            checks++;
            if (wr_log[wb+i] !== 32'(4*i) || rd_log[rb+i] !== 32'(4*i)) begin
               failures++;
               $display("FAIL default_addr[%0d]: got wr=%h rd=%h required %h", i, wr_log[wb+i],
                        rd_log[rb+i], 4*i);
            end
            checks++;
            if (mem[i] !== 32'(i + 1)) begin
               failures++; $display("FAIL default_mem[%0d]: got %h required %h", i, mem[i], i + 1);
            end
         end
      end
      checks++;
      if (r_strb_bad != 0) begin
         failures++; $display("FAIL default_wstrb: got %0d bad cycles required 0", r_strb_bad);
      end
   endtask

   task automatic test_wait_states();
      logic [31:0] w [NR];
      for (int i = 0; i < NR; i++) w[i] = 32'h5500_0000 + 32'(i);
      load_words(w);
      aw_lat = 3; w_lat = 1;
      run_seq(-1, -1);
      aw_lat = 0; w_lat = 0;
      checks++;
      if (r_aw_hi != 4 * NR || r_w_hi != 2 * NR) begin
         failures++;
         $display("FAIL wait_valid_cycles: got aw=%0d w=%0d required aw=%0d w=%0d", r_aw_hi,
                  r_w_hi, 4 * NR, 2 * NR);
      end
      checks++;
      if (r_done_cyc < 0 || error !== 1'b0) begin
         failures++; $display("FAIL wait_done: got done_cyc=%0d error=%0b required done, 0",
                              r_done_cyc, error);
      end
      for (int i = 0; i < NR; i++) begin
         checks++;
         if (mem[i] !== w[i]) begin
            failures++; $display("FAIL wait_mem[%0d]: got %h required %h", i, mem[i], w[i]);
         end
      end
   endtask

   task automatic test_bresp_error();
      logic [31:0] w [NR];
      int wb, rb;
      for (int i = 0; i < NR; i++) w[i] = 32'hA0 + 32'(i);
      load_words(w);
      bresp_err_idx = 2;
      wb = wr_log.size(); rb = rd_log.size();
      run_seq(-1, -1);
      bresp_err_idx = -1;
      checks++;
      if (r_done_cyc < 0 || error !== 1'b1 || err_code !== 2'd1 || err_index !== 4'd2) begin
         failures++;
         $display("FAIL bresp_err: got done=%0d error=%0b code=%0d idx=%0d required 1/1/2",
                  r_done_cyc, error, err_code, err_index);
      end
      checks++;
      if (wr_log.size() - wb != 3 || rd_log.size() - rb != 0 || r_first_ar >= 0) begin
         failures++;
         $display("FAIL bresp_counts: got wr=%0d rd=%0d required wr=3 rd=0",
                  wr_log.size() - wb, rd_log.size() - rb);
      end
   endtask

   task automatic test_rdata_corrupt();
      logic [31:0] w [NR];
      for (int i = 0; i < NR; i++) w[i] = 32'(i + 1);
      load_words(w);
      corrupt_idx = 3;
      run_seq(-1, -1);
      corrupt_idx = -1;
      checks++;
      if (error !== 1'b1 || err_code !== 2'd2 || err_index !== 4'd3) begin
         failures++; $display("FAIL corrupt_err: got error=%0b code=%0d idx=%0d required 1/2/3",
                              error, err_code, err_index);
      end
      checks++;
      if (r_done_cyc != EXP_DONE) begin
         failures++; $display("FAIL corrupt_done_cycle: got %0d required %0d", r_done_cyc, EXP_DONE);
      end
   endtask

   task automatic test_timeout();
      ar_never = 1'b1;
      run_seq(-1, -1);
      ar_never = 1'b0;
      checks++;
      if (r_done_cyc < 0 || r_first_ar != EXP_AR || r_done_cyc - r_first_ar != TO) begin
         failures++;
         $display("FAIL timeout_cycle: got first_ar=%0d done=%0d required %0d and %0d", r_first_ar,
                  r_done_cyc, EXP_AR, EXP_AR + TO);
      end
      checks++;
      if (error !== 1'b1 || err_code !== 2'd3 || err_index !== 4'd0) begin
         failures++; $display("FAIL timeout_err: got error=%0b code=%0d idx=%0d required 1/3/0",
                              error, err_code, err_index);
      end
      checks++;
      if (r_ar_late) begin
         failures++; $display("FAIL timeout_arvalid_drop: got ARVALID high after done required low");
      end
      pulse_reset();
   endtask

   task automatic test_busy_and_reset();
      logic [31:0] w [NR];
      int wb;
      for (int i = 0; i < NR; i++) w[i] = 32'h1234_0000 + 32'(i);
      load_words(w);
      wb = wr_log.size();
      run_seq(4, -1);
      checks++;
      if (r_n_done != 1 || wr_log.size() - wb != NR || r_done_cyc != EXP_DONE) begin
         failures++;
         $display("FAIL busy_ignore: got dones=%0d writes=%0d done=%0d required 1/%0d/%0d",
                  r_n_done, wr_log.size() - wb, r_done_cyc, NR, EXP_DONE);
      end
      run_seq(-1, 5);
      checks++;
      if (r_n_done != 0) begin
         failures++; $display("FAIL reset_no_done: got %0d done pulses required 0", r_n_done);
      end
      for (int i = 0; i < NR; i++) w[i] = 32'hBEEF_0000 + 32'(i);
      load_words(w);
      run_seq(-1, -1);
      checks++;
      if (r_n_done != 1 || r_done_cyc != EXP_DONE || error !== 1'b0) begin
         failures++;
         $display("FAIL after_reset_run: got dones=%0d done=%0d error=%0b required 1/%0d/0",
                  r_n_done, r_done_cyc, error, EXP_DONE);
      end
      for (int i = 0; i < NR; i++) begin
         checks++;
         if (mem[i] !== w[i]) begin
            failures++; $display("FAIL after_reset_mem[%0d]: got %h required %h", i, mem[i], w[i]);
         end
      end
   endtask

   // Reference: writes stop at the first bad BRESP; reads happen only if all
   // writes were good and stop at the first mismatching word.
   task automatic test_random();
      logic [31:0] w [NR];
      int wb, rb, mode, exp_code, exp_idx, nw, nr;
      for (int it = 0; it < 8; it++) begin
         for (int i = 0; i < NR; i++) w[i] = $urandom;
         load_words(w);
         aw_lat = $urandom_range(0, 3);
         w_lat  = $urandom_range(0, 3);
         ar_lat = $urandom_range(0, 3);
         mode   = $urandom_range(0, 2);
         bresp_err_idx = (mode == 1) ? $urandom_range(0, NR - 1) : -1;
         corrupt_idx   = (mode == 2) ? $urandom_range(0, NR - 1) : -1;
         exp_code = 0; exp_idx = 0; nw = NR; nr = NR;
         for (int i = 0; i < NR; i++) begin
            if (exp_code == 0 && bresp_err_idx == i) begin
               exp_code = 1; exp_idx = i; nw = i + 1; nr = 0;
            end
         end
         for (int i = 0; i < NR; i++) begin
            if (exp_code == 0 && corrupt_idx == i && w[i] != 32'd0) begin
               exp_code = 2; exp_idx = i; nr = i + 1;
            end
         end
         wb = wr_log.size(); rb = rd_log.size();
         run_seq(-1, -1);
         checks++;
         if (r_n_done != 1 || error !== (exp_code != 0) || err_code !== 2'(exp_code) ||
             err_index !== 4'(exp_idx)) begin
            failures++;
            $display("FAIL random[%0d]_result: got dones=%0d code=%0d idx=%0d required 1/%0d/%0d",
                     it, r_n_done, err_code, err_index, exp_code, exp_idx);
         end
         checks++;
         if (wr_log.size() - wb != nw || rd_log.size() - rb != nr) begin
            failures++;
            $display("FAIL random[%0d]_counts: got wr=%0d rd=%0d required wr=%0d rd=%0d", it,
                     wr_log.size() - wb, rd_log.size() - rb, nw, nr);
         end else begin
            for (int i = 0; i < nw; i++) begin
               checks++;
               if (wr_log[wb+i] !== 32'(4*i) || mem[i] !== w[i]) begin
                  failures++;
                  $display("FAIL random[%0d]_write[%0d]: got addr=%h data=%h required %h/%h", it,
                           i, wr_log[wb+i], mem[i], 4*i, w[i]);
               end
            end
         end
      end
      aw_lat = 0; w_lat = 0; ar_lat = 0;
      bresp_err_idx = -1; corrupt_idx = -1;
   endtask

   initial begin
      test_reset();
      test_default();
      test_wait_states();
      test_bresp_error();
      test_rdata_corrupt();
      test_timeout();
      test_busy_and_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/scaling_cfg_sequencer.md
# scaling_cfg_sequencer

AXI4-Lite master that programs the scaling interface's register bank from a single start pulse. It writes `NUM_REGS` 32-bit configuration words to consecutive register addresses. It can then read each one back and compare it against the value written. It reports completion and the first failure (slave error response, readback mismatch, or bus timeout). It sits between the control logic and the scaling interface's S00_AXI port, replacing manual register programming.

## Interface
Parameters:
- `C_M_AXI_ADDR_WIDTH`, 32, address width
- `C_M_AXI_DATA_WIDTH`, 32, data width; fixed at 32
- `NUM_REGS`, 4, registers to program, 1..16
- `BASE_ADDR`, 0, address of register 0; register i is at `BASE_ADDR + 4*i`
- `VERIFY`, 1, 1 = read back and compare after the writes; 0 = writes only
- `TIMEOUT_CYCLES`, 255, maximum cycles to wait for any single handshake

Ports:
- `ACLK`  in  1  clock
- `ARESET`  in  1  synchronous, active-high reset
- `start`  in  1  begin a sequence; sampled only in IDLE
- `cfg_data`  in  32*NUM_REGS  word i at bits [32i+31:32i]; captured when start is accepted
- `busy`  out  1  high from the cycle after start is accepted until done
- `done`  out  1  one-cycle completion pulse
- `error`  out  1  valid with done; held until the next accepted start
- `err_code`  out  2  0 = none, 1 = BRESP/RRESP ≠ OKAY, 2 = readback mismatch, 3 = timeout
- `err_index`  out  4  register index of the first failure
- `M_AXI_AWADDR/AWPROT/AWVALID/AWREADY`, `M_AXI_WDATA/WSTRB/WVALID/WREADY`, `M_AXI_BRESP/BVALID/BREADY`, `M_AXI_ARADDR/ARPROT/ARVALID/ARREADY`, `M_AXI_RDATA/RRESP/RVALID/RREADY`  standard AXI4-Lite master channels
- `AWPROT`/`ARPROT` are tied to 0; `WSTRB` is all ones.

## Operation
State machine: IDLE → WR_REQ → WR_RESP → (next index: WR_REQ) → RD_REQ → RD_RESP → (next index: RD_REQ) → DONE → IDLE. With `VERIFY=0`, the machine goes from the last WR_RESP directly to DONE.

- **IDLE:** `start=1` captures `cfg_data`, sets index = 0, clears `error`/`err_code`/`err_index`, and enters WR_REQ.
- **WR_REQ:**
  - `AWVALID` and `WVALID` are asserted together with address and data for the current index.
  - Each valid drops independently after its own handshake.
  - The state exits to WR_RESP once both handshakes have occurred, in either order or the same cycle.
- **WR_RESP:**
  - `BREADY=1`.
  - On `BVALID`: `BRESP≠0` → error code 1, go to DONE. Otherwise go to the next index, or to the read phase after the last index (index reset to 0).
- **RD_REQ:** `ARVALID` is held until `ARREADY`, then go to RD_RESP.
- **RD_RESP:**
  - `RREADY=1`.
  - On `RVALID`: `RRESP≠0` → code 1. Otherwise `RDATA≠` captured word → code 2.
  - Any error goes to DONE; otherwise go to the next index, or to DONE after the last index.
- **DONE:** `done=1` for one cycle, `busy=0`, return to IDLE.
- **Timeout counter:**
  - Clears on entry to every WR_REQ/WR_RESP/RD_REQ/RD_RESP state and increments each cycle in it.
  - Reaching `TIMEOUT_CYCLES` → code 3, all valids/readies drop, go to DONE.
  - Dropping valids on timeout is a deliberate abort for a hung bus; the slave requires `ARESET` before reuse.
- Only the first error is recorded; the sequence stops at it.
- `start` while busy is ignored (not queued).

## Timing
- Reset value of every output: 0, including all VALID/READY and address/data.
- `ARESET` mid-sequence: the block returns to IDLE in the next cycle, valids drop, and no done pulse is produced.
- Cycle 0 = the cycle `start` is sampled high. `AWVALID`/`WVALID` are first high in cycle 1 (registered outputs).
- Zero-wait slave (readies high, B/R one cycle after the address handshake):
  - each write takes 2 cycles, each read takes 2 cycles;
  - `done` occurs in cycle `1+4*NUM_REGS` (17 for defaults) with `VERIFY=1`, or in cycle `1+2*NUM_REGS` with `VERIFY=0`.
- `done`, `error`, `err_code`, `err_index` update in the same cycle; `busy` falls in that cycle.
- A new start is accepted at the earliest in the cycle after `done`.

## Test plan
- **Defaults, zero-wait scaling interface slave, cfg words 1,2,3,4:**
  - writes go to 0x0, 0x4, 0x8, 0xC, then reads in the same order;
  - `done` occurs in cycle 17 with `error=0`;
  - the slave registers hold 1..4.
- **WREADY at cycle+1, AWREADY at cycle+3:**
  - `WVALID` drops after its handshake while `AWVALID` is held;
  - the sequence completes with `error=0`.
- **Slave returns `BRESP=2'b10` for index 2:**
  - `done` with `err_code=1`, `err_index=2`;
  - no AR transactions issued, index 3 never written.
- **Slave corrupts `RDATA` of index 3 (returns 0):** `err_code=2`, `err_index=3`, with `done` immediately after that read.
- **`ARREADY` never asserted:** `done` occurs `TIMEOUT_CYCLES` (255) cycles after RD_REQ entry, with `err_code=3`, `err_index=0`, and `ARVALID` low afterwards.
- **Busy and reset handling:**
  - `start` pulsed again at cycle 4 → ignored, and exactly one sequence runs.
  - `ARESET` asserted at cycle 5 of a new run → all outputs 0 the next cycle and no `done`.
  - A subsequent start runs the full sequence cleanly.
